// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter.
// Holds the compare opcode encoding and the default widths used by
// cmp_arbiter and compare_core.
package cmp_pkg;

  localparam int CMP_DATA_WIDTH    = 32;
  localparam int CMP_OPCODE_LENGTH = 4;

  typedef enum logic [CMP_OPCODE_LENGTH-1:0] {
    CMP_SLT  = 4'b0000,  // signed a < b
    CMP_SLTU = 4'b0001,  // unsigned a < b
    CMP_EQ   = 4'b0010,  // a == b
    CMP_NE   = 4'b0011,  // a != b
    CMP_GE   = 4'b0100,  // signed a >= b
    CMP_GEU  = 4'b0101   // unsigned a >= b
  } cmp_op_e;

endpackage

// File: rtl/compare_core.sv
// Combinational compare datapath shared by both requesters.
// Ports:
//   op      in  compare opcode (cmp_op_e encoding)
//   a, b    in  operands, two's complement
//   result  out outcome in bit 0, upper bits zero
//   illegal out op is not one of the defined compare codes
module compare_core
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH    = CMP_DATA_WIDTH,
  parameter int OPCODE_LENGTH = CMP_OPCODE_LENGTH
) (
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     illegal
);

  logic lt_signed;
  logic lt_unsigned;
  logic outcome;

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    outcome = 1'b0;
    illegal = 1'b0;
    case (op)
      OPCODE_LENGTH'(CMP_SLT):  outcome = lt_signed;
      OPCODE_LENGTH'(CMP_SLTU): outcome = lt_unsigned;
      OPCODE_LENGTH'(CMP_EQ):   outcome = (a == b);
      OPCODE_LENGTH'(CMP_NE):   outcome = (a != b);
      OPCODE_LENGTH'(CMP_GE):   outcome = !lt_signed;
      OPCODE_LENGTH'(CMP_GEU):  outcome = !lt_unsigned;
      default:                  illegal = 1'b1;
    endcase
  end

  // Illegal ops leave outcome at 0, so result is all zeros for them.
  assign result = DATA_WIDTH'(outcome);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one compare datapath between the EX-stage ALU
// (port 0, SLT/SLTU) and the branch-resolution unit (port 1), followed by a
// single registered result stage.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req0_* / req1_*             request channels (valid/ready/op/a/b)
//   res_valid, res_ready        result channel handshake
//   res_id                      requester that issued the result
//   res_data                    compare outcome in bit 0, upper bits zero
//   res_illegal                 op was not a defined compare op
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Requesters hold valid/op/operands stable until ready. The result stage
// can take a new request whenever it is empty or being drained in the same
// cycle, which sustains one operation per clock.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH    = CMP_DATA_WIDTH,
  parameter int OPCODE_LENGTH = CMP_OPCODE_LENGTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_id,
  output logic [DATA_WIDTH-1:0]    res_data,
  output logic                     res_illegal
);

  logic                     last_grant;
  logic                     grant;
  logic                     accept;
  logic                     xfer_in;
  logic [OPCODE_LENGTH-1:0] sel_op;
  logic [DATA_WIDTH-1:0]    sel_a;
  logic [DATA_WIDTH-1:0]    sel_b;
  logic [DATA_WIDTH-1:0]    core_result;
  logic                     core_illegal;

  // On a tie the port that did not win last time is chosen; otherwise the
  // single valid port wins. With no valid request grant is a don't-care.
  assign grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  assign accept     = !res_valid || res_ready;
  assign req0_ready = !reset && accept && req0_valid && !grant;
  assign req1_ready = !reset && accept && req1_valid &&  grant;
  assign xfer_in    = req0_ready || req1_ready;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  compare_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_core (
    .op      (sel_op),
    .a       (sel_a),
    .b       (sel_b),
    .result  (core_result),
    .illegal (core_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_id      <= 1'b0;
      res_data    <= '0;
      res_illegal <= 1'b0;
      last_grant  <= 1'b1;  // port 0 wins the first tie
    end else if (xfer_in) begin
      res_valid   <= 1'b1;
      res_id      <= grant;
      res_data    <= core_result;
      res_illegal <= core_illegal;
      last_grant  <= grant;
    end else if (res_ready) begin
      res_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;

  localparam int W  = 32;
  localparam int OW = 4;
  localparam int EW = W + 2;  // {id, illegal, data}

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          res_valid, res_ready, res_id, res_illegal;
  logic [W-1:0]  res_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  bit m_valid;
  bit m_last;
  bit acc0, acc1;
  bit random_mode;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cmp_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_data    (res_data),
    .res_illegal (res_illegal)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference compare computed from the op definitions with plain integers.
  function automatic logic [EW-1:0] ref_result(input bit id, input logic [OW-1:0] op,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, sa, sb;
    bit o, ill;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[W-1] ? ub - 64'sh1_0000_0000 : ub;
    o = 1'b0;
    ill = 1'b0;
    case (op)
      4'd0: o = (sa < sb);
      4'd1: o = (ua < ub);
      4'd2: o = (ua == ub);
      4'd3: o = (ua != ub);
      4'd4: o = (sa >= sb);
      4'd5: o = (ua >= ub);
      default: ill = 1'b1;
    endcase
    ref_result = {id, ill, {(W-1){1'b0}}, o};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0: rand_operand = W'($urandom_range(0, 8));
      1: rand_operand = 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      2: rand_operand = 32'h8000_0000 + W'($urandom_range(0, 1));
      3: rand_operand = 32'h7FFF_FFFF;
      default: rand_operand = $urandom;
    endcase
  endfunction

  task automatic new_req(output logic v, output logic [OW-1:0] op,
                         output logic [W-1:0] a, output logic [W-1:0] b);
    int r;
    v = ($urandom_range(0, 3) != 0);
    r = $urandom_range(0, 9);
    if (r <= 6)      op = OW'($urandom_range(0, 5));
    else if (r == 7) op = 4'hF;
    else             op = OW'($urandom_range(6, 14));
    a = rand_operand();
    b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
  endtask

  // ---------------- driver: one clock per call ----------------
  task automatic step(input bit do_rst);
    bit nxt_valid, nxt_last, e0, e1, win;
    reset = do_rst;
    @(negedge clk);
    nxt_valid = m_valid;
    nxt_last  = m_last;
    if (reset) begin
      check("ready0_in_reset", req0_ready, 0);
      check("ready1_in_reset", req1_ready, 0);
      acc0 = 0;
      acc1 = 0;
    end else begin
      check("res_valid", res_valid, m_valid);
      win = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e0 = (!m_valid || res_ready) && req0_valid && (win == 0);
      e1 = (!m_valid || res_ready) && req1_valid && (win == 1);
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      acc0 = e0;
      acc1 = e1;
      if (e0) exp_q.push_back(ref_result(1'b0, req0_op, req0_a, req0_b));
      if (e1) exp_q.push_back(ref_result(1'b1, req1_op, req1_a, req1_b));
      if (e0 || e1) begin
        nxt_valid = 1;
        nxt_last  = e1;
      end else if (res_ready) begin
        nxt_valid = 0;
      end
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 0;
      m_last  = 1;
      exp_q.delete();  // pending result is discarded
    end else begin
      m_valid = nxt_valid;
      m_last  = nxt_last;
    end
    #1;
    if (random_mode) begin
      if (acc0 || !req0_valid) new_req(req0_valid, req0_op, req0_a, req0_b);
      if (acc1 || !req1_valid) new_req(req1_valid, req1_op, req1_a, req1_b);
      res_ready = ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic send(input bit port, input logic [OW-1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 0;
    if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 10 && !done; i++) begin
      step(0);
      done = port ? acc1 : acc0;
    end
    if (!done) check("send_timeout", 0, 1);
    if (port) req1_valid = 0; else req0_valid = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {res_id, res_illegal, res_data}, '0);
        end else begin
          check("result", {res_id, res_illegal, res_data}, exp_q[0]);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; random_mode = 0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    res_ready = 1;
    m_valid = 0; m_last = 1;
    @(posedge clk); #1;
    step(1);
    step(1);
    check("reset_valid", res_valid, 0);
    check("reset_data", res_data, 0);
    check("reset_id", res_id, 0);
    check("reset_illegal", res_illegal, 0);

    // basic SLT from ALU port
    send(0, 4'h0, 32'd5, 32'd10);
    step(0);
    // branch port signed/unsigned pair
    send(1, 4'h0, 32'hFFFF_FFFF, 32'd1);
    send(1, 4'h1, 32'hFFFF_FFFF, 32'd1);
    send(1, 4'h5, 32'hFFFF_FFFF, 32'd1);
    step(0);

    // both valid every cycle -> alternating grants, one per cycle
    req0_valid = 1; req0_op = 4'h2; req0_a = 32'd7; req0_b = 32'd7;
    req1_valid = 1; req1_op = 4'h3; req1_a = 32'd7; req1_b = 32'd8;
    for (int i = 0; i < 8; i++) step(0);

    // backpressure with both valid
    res_ready = 0;
    for (int i = 0; i < 3; i++) step(0);
    res_ready = 1;
    for (int i = 0; i < 4; i++) step(0);
    req0_valid = 0; req1_valid = 0;
    step(0);

    // illegal opcode
    send(0, 4'hF, 32'd3, 32'd7);
    step(0);

    // reset while a result is held, then a tie
    req0_valid = 1; req0_op = 4'h4; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_op = 4'h4; req1_a = 32'd2; req1_b = 32'd1;
    res_ready = 0;
    step(0);
    step(0);
    step(1);
    res_ready = 1;
    for (int i = 0; i < 4; i++) step(0);
    req0_valid = 0; req1_valid = 0;
    step(0);

    // randomized traffic with occasional resets
    random_mode = 1;
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 199) == 0);

    // drain
    random_mode = 0;
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    for (int i = 0; i < 4; i++) step(0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
